// File: rtl/sdram_port_arbiter.sv
// ---------------------------------------------------------------------------
// sdram_port_arbiter
//
// Shares the single byte-wide SDRAM controller port between three requesters:
// the ROM/artwork loader (writes), the CPU fetch path (reads) and the VFD
// compositor (reads). One transaction is in flight at a time. Priority is
// loader > CPU > VFD. A starvation guard hands the port to the VFD once the
// CPU has won STARVE_LIMIT consecutive arbitrations while the VFD was waiting.
//
// Transaction flow: IDLE -> ISSUE -> WAIT -> DONE -> IDLE.
//   IDLE  : pick an owner, latch its address (and write byte).
//   ISSUE : one-cycle mem_we (loader) or mem_rd (CPU/VFD) strobe.
//   WAIT  : hold mem_addr/mem_din until mem_ready; capture mem_dout.
//   DONE  : one-cycle ack to the owner.
//
// Parameters:
//   ADDR_W        SDRAM byte address width
//   STARVE_LIMIT  consecutive CPU grants tolerated while VFD is pending (1..255)
//
// Ports:
//   clk, reset_n                  clock, asynchronous active-low reset
//   ld_req/ld_addr/ld_data/ld_ack loader write port (level req, pulse ack)
//   cpu_req/cpu_addr/cpu_data/cpu_ack  CPU read port
//   vfd_req/vfd_addr/vfd_data/vfd_ack  compositor read port
//   mem_addr/mem_din/mem_dout     controller address / write byte / read byte
//   mem_rd/mem_we                 one-cycle strobes to the controller
//   mem_ready                     controller completion pulse
//   wd_err                        sticky watchdog flag (watchdog build only)
//   busy                          high whenever the FSM is not in IDLE
//
// Build option:
//   SDRAM_ARB_WATCHDOG_EN  when defined, a WAIT that sees no mem_ready for 255
//                          cycles is aborted: reads return 8'hFF, the ack
//                          still pulses and wd_err latches until reset.
// ---------------------------------------------------------------------------
module sdram_port_arbiter #(
  parameter int ADDR_W       = 25,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [7:0]        ld_data,
  output logic              ld_ack,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic [7:0]        cpu_data,
  output logic              cpu_ack,
  input  logic              vfd_req,
  input  logic [ADDR_W-1:0] vfd_addr,
  output logic [7:0]        vfd_data,
  output logic              vfd_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_din,
  input  logic [7:0]        mem_dout,
  output logic              mem_rd,
  output logic              mem_we,
  input  logic              mem_ready,
`ifdef SDRAM_ARB_WATCHDOG_EN
  output logic              wd_err,
`endif
  output logic              busy
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [7:0] STARVE_MAX = 8'(STARVE_LIMIT);

  // Requester index used for the one-hot owner/grant/ack vectors:
  // bit 0 = loader, bit 1 = CPU, bit 2 = VFD.
  logic [1:0]        state_reg;
  logic [1:0]        state_next;
  logic [2:0]        owner_reg;
  logic [2:0]        grant_oh;
  logic [2:0]        ack_reg;
  logic [7:0]        starve_reg;
  logic              starved;
  logic              mem_rd_reg;
  logic              mem_we_reg;
  logic [ADDR_W-1:0] mem_addr_reg;
  logic [7:0]        mem_din_reg;
  logic [ADDR_W-1:0] grant_addr;
  logic              wd_timeout;
  logic              xfer_done;

  logic [ADDR_W-1:0] req_addr  [3];
  logic [ADDR_W-1:0] addr_term [3];

  assign req_addr[0] = ld_addr;
  assign req_addr[1] = cpu_addr;
  assign req_addr[2] = vfd_addr;

  // The VFD has waited through enough CPU wins; it jumps ahead of the CPU.
  assign starved = vfd_req && (starve_reg >= STARVE_MAX);

  always_comb begin
    grant_oh = 3'b000;
    if (ld_req) begin
      grant_oh = 3'b001;
    end else if (starved) begin
      grant_oh = 3'b100;
    end else if (cpu_req) begin
      grant_oh = 3'b010;
    end else if (vfd_req) begin
      grant_oh = 3'b100;
    end
  end

  // AND-OR address mux driven by the one-hot grant.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_addr_sel
      assign addr_term[gi] = grant_oh[gi] ? req_addr[gi] : '0;
    end
  endgenerate

  assign grant_addr = addr_term[0] | addr_term[1] | addr_term[2];

  // Completion: the controller answered, or the watchdog gave up.
  assign xfer_done = (state_reg == ST_WAIT) && (mem_ready || wd_timeout);

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      ST_IDLE:  if (|grant_oh) state_next = ST_ISSUE;
      ST_ISSUE: state_next = ST_WAIT;
      ST_WAIT:  if (xfer_done) state_next = ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= ST_IDLE;
      owner_reg    <= '0;
      ack_reg      <= '0;
      mem_rd_reg   <= 1'b0;
      mem_we_reg   <= 1'b0;
      mem_addr_reg <= '0;
      mem_din_reg  <= '0;
      starve_reg   <= '0;
    end else begin
      state_reg  <= state_next;
      mem_rd_reg <= 1'b0;
      mem_we_reg <= 1'b0;
      ack_reg    <= '0;

      // Strobe is registered on the grant edge so it is high exactly while
      // the FSM sits in ISSUE.
      if (state_reg == ST_IDLE && |grant_oh) begin
        owner_reg    <= grant_oh;
        mem_addr_reg <= grant_addr;
        mem_we_reg   <= grant_oh[0];
        mem_rd_reg   <= ~grant_oh[0];
        if (grant_oh[0]) begin
          mem_din_reg <= ld_data;
        end
      end

      if (xfer_done) begin
        ack_reg <= owner_reg;
      end

      // Count CPU wins only while the VFD is actually waiting.
      if (state_reg == ST_IDLE) begin
        if (!vfd_req || grant_oh[2]) begin
          starve_reg <= '0;
        end else if (grant_oh[1] && starve_reg != 8'hFF) begin
          starve_reg <= starve_reg + 8'd1;
        end
      end
    end
  end

  // Read-data holding registers for the two read ports (CPU, VFD). They load
  // on the same edge that raises the ack, so data and ack appear together.
  generate
    for (gi = 0; gi < 2; gi++) begin : g_rd_port
      logic [7:0] data_reg;
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          data_reg <= '0;
        end else if (xfer_done && owner_reg[gi+1]) begin
          data_reg <= mem_ready ? mem_dout : 8'hFF;
        end
      end
    end
  endgenerate

`ifdef SDRAM_ARB_WATCHDOG_EN
  logic [7:0] wd_cnt_reg;
  logic       wd_err_reg;

  // wd_cnt_reg holds the index of the current WAIT cycle; index 254 is the
  // 255th cycle, after which the transaction is abandoned.
  assign wd_timeout = (state_reg == ST_WAIT) && !mem_ready && (wd_cnt_reg == 8'd254);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wd_cnt_reg <= '0;
      wd_err_reg <= 1'b0;
    end else begin
      if (state_reg == ST_WAIT) begin
        wd_cnt_reg <= wd_cnt_reg + 8'd1;
      end else begin
        wd_cnt_reg <= '0;
      end
      if (wd_timeout) begin
        wd_err_reg <= 1'b1;
      end
    end
  end

  assign wd_err = wd_err_reg;
`else
  assign wd_timeout = 1'b0;
`endif

  assign ld_ack   = ack_reg[0];
  assign cpu_ack  = ack_reg[1];
  assign vfd_ack  = ack_reg[2];
  assign cpu_data = g_rd_port[0].data_reg;
  assign vfd_data = g_rd_port[1].data_reg;
  assign mem_addr = mem_addr_reg;
  assign mem_din  = mem_din_reg;
  assign mem_rd   = mem_rd_reg;
  assign mem_we   = mem_we_reg;
  assign busy     = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sdram_port_arbiter
//
// Randomised requesters and a randomised SDRAM controller drive the arbiter.
// A transaction-level reference model predicts, from the arbitration rules and
// the latency arithmetic (grant at g, strobe at g+1, ready at g+1+L, ack at
// g+2+L, next arbitration at g+3+L), every output in every cycle.
// Phases: mixed random traffic, continuous CPU+VFD contention, watchdog
// timeout (watchdog build only), reset during WAIT, more random traffic.
// ---------------------------------------------------------------------------
module tb_sdram_port_arbiter;

  localparam int ADDR_W       = 25;
  localparam int STARVE_LIMIT = 8;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              ld_req = 1'b0;
  logic [ADDR_W-1:0] ld_addr = '0;
  logic [7:0]        ld_data = '0;
  logic              ld_ack;
  logic              cpu_req = 1'b0;
  logic [ADDR_W-1:0] cpu_addr = '0;
  logic [7:0]        cpu_data;
  logic              cpu_ack;
  logic              vfd_req = 1'b0;
  logic [ADDR_W-1:0] vfd_addr = '0;
  logic [7:0]        vfd_data;
  logic              vfd_ack;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_din;
  logic [7:0]        mem_dout = '0;
  logic              mem_rd;
  logic              mem_we;
  logic              mem_ready = 1'b0;
  logic              busy;
`ifdef SDRAM_ARB_WATCHDOG_EN
  logic              wd_err;
`endif

  sdram_port_arbiter #(
    .ADDR_W      (ADDR_W),
    .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .ld_req   (ld_req),
    .ld_addr  (ld_addr),
    .ld_data  (ld_data),
    .ld_ack   (ld_ack),
    .cpu_req  (cpu_req),
    .cpu_addr (cpu_addr),
    .cpu_data (cpu_data),
    .cpu_ack  (cpu_ack),
    .vfd_req  (vfd_req),
    .vfd_addr (vfd_addr),
    .vfd_data (vfd_data),
    .vfd_ack  (vfd_ack),
    .mem_addr (mem_addr),
    .mem_din  (mem_din),
    .mem_dout (mem_dout),
    .mem_rd   (mem_rd),
    .mem_we   (mem_we),
    .mem_ready(mem_ready),
`ifdef SDRAM_ARB_WATCHDOG_EN
    .wd_err   (wd_err),
`endif
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Requesters: 0 = loader, 1 = CPU, 2 = VFD
  bit                pend   [3];
  logic [ADDR_W-1:0] r_addr [3];
  logic [7:0]        r_data;
  int                prob   [3];

  // Reference model
  int                cyc = 0;
  int                g_cyc = -100;
  int                end_cyc = -100;
  int                lat = 0;
  int                own = 0;
  int                starve_cnt = 0;
  logic [ADDR_W-1:0] m_addr = '0;
  logic [7:0]        m_din = '0;
  logic [7:0]        m_dout = '0;
  logic [7:0]        m_cpu_data = '0;
  logic [7:0]        m_vfd_data = '0;
  bit                m_wd_err = 1'b0;
  bit                wd_txn = 1'b0;
  bit                wd_next = 1'b0;
  bit                wd_done = 1'b0;
  int                ack_count [3];
  int                txn_no = 0;

  // Starvation pattern tracking
  bit                starve_track = 1'b0;
  bit                seen_vfd = 1'b0;
  int                cpu_run = 0;
  int                vfd_runs = 0;

  task automatic cycle_body(input bit stale);
    bit issue;
    bit done;
    int w;
    cyc++;
    issue = (cyc == g_cyc + 1);
    done  = (cyc == end_cyc);

    if (done && own == 1) m_cpu_data = wd_txn ? 8'hFF : m_dout;
    if (done && own == 2) m_vfd_data = wd_txn ? 8'hFF : m_dout;
    if (done && wd_txn)   m_wd_err = 1'b1;

    check("mem_rd",   mem_rd,   issue && own != 0);
    check("mem_we",   mem_we,   issue && own == 0);
    check("ld_ack",   ld_ack,   done && own == 0);
    check("cpu_ack",  cpu_ack,  done && own == 1);
    check("vfd_ack",  vfd_ack,  done && own == 2);
    check("busy",     busy,     cyc >= g_cyc + 1 && cyc <= end_cyc);
    check("cpu_data", cpu_data, m_cpu_data);
    check("vfd_data", vfd_data, m_vfd_data);
`ifdef SDRAM_ARB_WATCHDOG_EN
    check("wd_err",   wd_err,   m_wd_err);
`endif
    if (cyc >= g_cyc + 1 && cyc <= g_cyc + 1 + lat) begin
      check("mem_addr", mem_addr, m_addr);
      if (own == 0) check("mem_din", mem_din, m_din);
    end

    if (done) begin
      txn_no++;
      ack_count[own]++;
      $display("txn %0d: owner=%0d addr=%h wdata=%h rdata=%h lat=%0d",
               txn_no, own, m_addr, m_din, (own == 1) ? m_cpu_data : m_vfd_data, lat);
      if (wd_txn) wd_done = 1'b1;
      if (starve_track) begin
        if (own == 1) cpu_run++;
        if (own == 2) begin
          if (seen_vfd) begin
            check("starve_run", cpu_run, STARVE_LIMIT);
            vfd_runs++;
          end
          seen_vfd = 1'b1;
          cpu_run = 0;
        end
      end
    end

    // Requesters: drop after ack, maybe raise a fresh request.
    for (int r = 0; r < 3; r++) begin
      if (done && own == r) pend[r] = 1'b0;
      if (!pend[r] && $urandom_range(99) < prob[r]) begin
        pend[r]   = 1'b1;
        r_addr[r] = ADDR_W'($urandom);
        if (r == 0) r_data = 8'($urandom);
      end
    end
    ld_req   = pend[0];
    ld_addr  = r_addr[0];
    ld_data  = r_data;
    cpu_req  = pend[1];
    cpu_addr = r_addr[1];
    vfd_req  = pend[2];
    vfd_addr = r_addr[2];

    // Arbitration happens in any cycle the arbiter is idle.
    if (cyc > end_cyc) begin
      if (!pend[2]) starve_cnt = 0;
      w = -1;
      if (pend[0])                                  w = 0;
      else if (pend[2] && starve_cnt >= STARVE_LIMIT) w = 2;
      else if (pend[1])                             w = 1;
      else if (pend[2])                             w = 2;
      if (w >= 0) begin
        own     = w;
        g_cyc   = cyc;
        wd_txn  = wd_next;
        wd_next = 1'b0;
        lat     = wd_txn ? 255 : int'($urandom_range(6, 1));
        end_cyc = cyc + 2 + lat;
        m_addr  = r_addr[w];
        if (w == 0) m_din = r_data;
        m_dout  = 8'($urandom);
        if (w == 2) starve_cnt = 0;
        else if (w == 1 && pend[2]) starve_cnt++;
      end
    end

    // Controller: the real completion lands at g+1+L; stray pulses are only
    // generated outside the WAIT window, where they must be ignored.
    if (cyc >= g_cyc + 2 && cyc <= g_cyc + 1 + lat) begin
      mem_ready = (cyc == g_cyc + 1 + lat) && !wd_txn;
      mem_dout  = mem_ready ? m_dout : 8'($urandom);
    end else begin
      mem_ready = stale || ($urandom_range(7) == 0);
      mem_dout  = 8'($urandom);
    end
  endtask

  task automatic do_cycle();
    @(negedge clk);
    cycle_body(1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_mem_rd"},   mem_rd,   1'b0);
    check({tag, "_mem_we"},   mem_we,   1'b0);
    check({tag, "_acks"},     {ld_ack, cpu_ack, vfd_ack}, 3'b000);
    check({tag, "_busy"},     busy,     1'b0);
    check({tag, "_mem_addr"}, mem_addr, '0);
    check({tag, "_mem_din"},  mem_din,  '0);
    check({tag, "_cpu_data"}, cpu_data, '0);
    check({tag, "_vfd_data"}, vfd_data, '0);
`ifdef SDRAM_ARB_WATCHDOG_EN
    check({tag, "_wd_err"},   wd_err,   1'b0);
`endif
  endtask

  task automatic do_reset_mid();
    @(negedge clk);
    reset_n   = 1'b0;
    mem_ready = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    @(negedge clk);
    reset_n    = 1'b1;
    g_cyc      = -100;
    end_cyc    = -100;
    lat        = 0;
    starve_cnt = 0;
    m_cpu_data = '0;
    m_vfd_data = '0;
    m_wd_err   = 1'b0;
    wd_txn     = 1'b0;
    wd_next    = 1'b0;
    // Stale completion from the aborted transaction arrives right after release.
    cycle_body(1'b1);
  endtask

  initial begin
    bit found;
    int vfd_before;
    for (int r = 0; r < 3; r++) begin
      pend[r] = 1'b0; r_addr[r] = '0; prob[r] = 0; ack_count[r] = 0;
    end
    r_data = '0;

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset_n = 1'b1;

    // Mixed random traffic
    prob[0] = 20; prob[1] = 50; prob[2] = 40;
    repeat (1500) do_cycle();

    // CPU and VFD both hammering: 8 CPU grants per VFD grant
    prob[0] = 0; prob[1] = 100; prob[2] = 100;
    starve_track = 1'b1;
    repeat (400) do_cycle();
    starve_track = 1'b0;
    check("starve_runs_seen", vfd_runs >= 3, 1'b1);

`ifdef SDRAM_ARB_WATCHDOG_EN
    // Controller never answers the next transaction
    prob[0] = 0; prob[1] = 0; prob[2] = 100;
    wd_next = 1'b1;
    for (int i = 0; i < 1000 && !wd_done; i++) do_cycle();
    check("wd_done", wd_done, 1'b1);
    repeat (50) do_cycle();
`endif

    // Reset while a VFD read is in WAIT
    prob[0] = 0; prob[1] = 50; prob[2] = 100;
    found = 1'b0;
    for (int i = 0; i < 500 && !found; i++) begin
      do_cycle();
      if (own == 2 && cyc + 1 >= g_cyc + 2 && cyc + 1 <= g_cyc + 1 + lat) found = 1'b1;
    end
    check("rst_setup", found, 1'b1);
    if (found) begin
      vfd_before = ack_count[2];
      do_reset_mid();
      for (int i = 0; i < 300 && ack_count[2] == vfd_before; i++) do_cycle();
      check("rst_regrant", ack_count[2] > vfd_before, 1'b1);
    end

    // More random traffic after reset
    prob[0] = 25; prob[1] = 60; prob[2] = 60;
    repeat (1000) do_cycle();

    check("txn_mix_ld",  ack_count[0] > 0, 1'b1);
    check("txn_mix_cpu", ack_count[1] > 0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sdram_port_arbiter.md
# sdram_port_arbiter

Shares the single byte-wide SDRAM controller port between three requesters: the ROM/artwork loader (writes), the CPU program/data fetch (reads) and the VFD compositor (mask and background reads). The block sits between the requesters and the SDRAM controller. It serialises one transaction at a time and applies fixed priority with a starvation guard, so the compositor keeps refreshing the frame buffer while the CPU runs.

## Interface
Parameters:
- ADDR_W, 25, SDRAM byte address width
- STARVE_LIMIT, 8, max consecutive CPU grants while VFD is pending (1..255)

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- ld_req  in  1  loader write request, level, held until ld_ack
- ld_addr  in  ADDR_W  loader address
- ld_data  in  8  loader write byte
- ld_ack  out  1  one-cycle pulse, write completed
- cpu_req  in  1  CPU read request, level
- cpu_addr  in  ADDR_W  CPU address
- cpu_data  out  8  CPU read byte, valid with cpu_ack, held until next cpu_ack
- cpu_ack  out  1  one-cycle pulse
- vfd_req  in  1  compositor read request, level
- vfd_addr  in  ADDR_W  compositor address
- vfd_data  out  8  compositor read byte, valid with vfd_ack, held until next vfd_ack
- vfd_ack  out  1  one-cycle pulse
- mem_addr  out  ADDR_W  address to controller
- mem_din  out  8  write byte to controller
- mem_dout  in  8  read byte from controller
- mem_rd  out  1  one-cycle read strobe
- mem_we  out  1  one-cycle write strobe
- mem_ready  in  1  controller completion pulse; mem_dout valid in the same cycle
- busy  out  1  high when not in IDLE

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE: if any request is pending, select the owner, latch its address and data into mem_addr/mem_din, and go to ISSUE.
- Priority order: loader > CPU > VFD. Override: if vfd_req has been pending through STARVE_LIMIT consecutive CPU grants, VFD wins the next arbitration (a loader request still beats it). The starve counter clears on any VFD grant, and also when vfd_req is low in IDLE.
- ISSUE: pulse mem_we (loader) or mem_rd (CPU/VFD) for exactly one cycle, then go to WAIT.
- WAIT: hold mem_addr/mem_din stable. On mem_ready, capture mem_dout into the owner's data register and go to DONE.
- DONE: pulse the owner's ack for one cycle, then go to IDLE. Owner and data register update together.
- A requester must hold req, addr and data until its ack. A req dropped after grant is a protocol violation: the transaction still completes and the ack still pulses. A requester that keeps req high after ack gets a new transaction; consecutive grants to the same requester are allowed.
- A mem_ready pulse outside WAIT is ignored.
- Simultaneous requests in one IDLE cycle: a single grant per the rules above; the losers stay pending.

## Timing
- Reset values: all acks 0, mem_rd 0, mem_we 0, mem_addr 0, mem_din 0, cpu_data 0, vfd_data 0, busy 0, state IDLE, starve counter 0.
- Reset asserted mid-transaction aborts it immediately. No ack is issued, and strobes drop asynchronously.
- Latency: req seen in IDLE at cycle n, strobe at n+1, mem_ready at n+1+L (L≥1), ack at n+2+L. Back-to-back throughput is one transaction per L+3 cycles.
- Ack, data and strobes are all registered. No combinational path from req to mem_* or to ack.

## Configuration
- SDRAM_ARB_WATCHDOG_EN defined: WAIT counts cycles with an 8-bit counter. If 255 cycles pass without mem_ready, the transaction is aborted: the owner's data register is loaded with 8'hFF (reads only), the ack pulses via DONE, and the sticky output wd_err goes to 1. wd_err clears only on reset.
- SDRAM_ARB_WATCHDOG_EN undefined: WAIT waits indefinitely. wd_err does not exist and no counter is built.

## Test plan
- Single CPU read, controller L=2, mem_dout=8'h5A: mem_rd pulse at n+1, cpu_ack at n+4, cpu_data=8'h5A held after.
- ld_req, cpu_req and vfd_req rise in the same cycle: grant order is loader, CPU, VFD; each ack fires once; mem_we only for the loader transaction.
- CPU and VFD requests held continuously, STARVE_LIMIT=8: exactly 8 CPU acks, then 1 VFD ack, repeating.
- Loader write addr 25'h4B000, data 8'h3C: mem_addr=25'h4B000 and mem_din=8'h3C stable from ISSUE through WAIT; ld_ack one cycle after mem_ready.
- reset_n pulsed low during WAIT: all outputs 0 immediately; a pending vfd_req is regranted after release; the stale mem_ready produces no ack.
- With SDRAM_ARB_WATCHDOG_EN, mem_ready withheld: vfd_ack at 255 WAIT cycles + 1, vfd_data=8'hFF, wd_err=1 until reset.
